// File: rtl/tl_ul_client_arbiter.sv
// ---------------------------------------------------------------------------
// tl_ul_client_arbiter
//
// Purpose:
//   Shares one TileLink-UL manager port between two clients (for example the
//   debug master and the system-bus master).
//
//   A channel:
//     - Round-robin arbitration between the two clients.
//     - The manager-side source ID is {client_idx, client_source}.
//     - A grant that the manager stalls is locked until it fires, so the
//       manager sees a stable request.
//   D channel:
//     - Responses are routed back to the issuing client by the source MSB.
//     - The MSB is stripped before the bits reach the clients.
//   In-flight limit:
//     - Each client may have at most MAX_INFLIGHT requests outstanding.
//   Both paths are combinational pass-through; no payload is stored.
//
// Parameters:
//   MAX_INFLIGHT  maximum outstanding A requests per client (1..7)
//   SRC_W         client source-ID width (manager side is SRC_W+1)
//
// Ports:
//   clock, reset_n             clock (rising edge), async active-low reset
//   cX_a_valid/ready/bits      client A channels, bits = {op,param,size,src,addr,mask,data}
//   m_a_valid/ready/bits       manager A channel, src widened by the client index
//   m_d_valid/ready/bits       manager D channel, bits = {op,param,size,src,denied,data,corrupt}
//   cX_d_valid/ready/bits      client D channels, source MSB removed
//   cX_busy                    client has at least one request in flight (registered)
//
// Optional feature (macro TL_UL_ARB_PERF_EN):
//   perf_grant0/perf_grant1    A fires per client, wrapping 32-bit counters
//   perf_stall                 cycles with m_a_valid & !m_a_ready
// ---------------------------------------------------------------------------
module tl_ul_client_arbiter #(
    parameter int MAX_INFLIGHT = 4,
    parameter int SRC_W        = 3
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                c0_a_valid,
    output logic                c0_a_ready,
    input  logic [77+SRC_W:0]   c0_a_bits,
    input  logic                c1_a_valid,
    output logic                c1_a_ready,
    input  logic [77+SRC_W:0]   c1_a_bits,

    output logic                m_a_valid,
    input  logic                m_a_ready,
    output logic [78+SRC_W:0]   m_a_bits,

    input  logic                m_d_valid,
    output logic                m_d_ready,
    input  logic [43+SRC_W:0]   m_d_bits,

    output logic                c0_d_valid,
    input  logic                c0_d_ready,
    output logic [42+SRC_W:0]   c0_d_bits,
    output logic                c1_d_valid,
    input  logic                c1_d_ready,
    output logic [42+SRC_W:0]   c1_d_bits,

    output logic                c0_busy,
    output logic                c1_busy
`ifdef TL_UL_ARB_PERF_EN
    ,
    output logic [31:0]         perf_grant0,
    output logic [31:0]         perf_grant1,
    output logic [31:0]         perf_stall
`endif
);

    // Field positions.
    // A channel:
    //   - Payload below the source is address+mask+data = 68 bits.
    //   - The source field therefore starts at bit 68.
    // D channel:
    //   - Payload below the source is denied+data+corrupt = 34 bits.
    //   - The manager-side source MSB therefore sits at bit 34+SRC_W.
    localparam int          A_W       = 78 + SRC_W;
    localparam int          A_SRC_LSB = 68;
    localparam int          A_SRC_TOP = A_SRC_LSB + SRC_W;
    localparam int          D_W       = 44 + SRC_W;
    localparam int          D_SRC_MSB = 34 + SRC_W;
    localparam logic [2:0]  MAX_CNT   = 3'(MAX_INFLIGHT);

    // Saturating up/down in-flight counter update.
    //   - Simultaneous inc and dec cancel.
    //   - A decrement at zero (a stray response) leaves the counter at zero.
    function automatic logic [2:0] next_count(input logic [2:0] cnt,
                                              input logic       inc,
                                              input logic       dec);
        logic [2:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + 3'd1;
            2'b01:   res = (cnt != 3'd0) ? (cnt - 3'd1) : 3'd0;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // State
    logic        rr_ptr_q, rr_ptr_d;
    logic        lock_q, lock_d;
    logic        lock_idx_q, lock_idx_d;
    logic [2:0]  inflight0_q, inflight0_d;
    logic [2:0]  inflight1_q, inflight1_d;
    logic        busy0_q, busy1_q;

    // Combinational helpers
    logic            elig0_s, elig1_s;
    logic            grant_s;
    logic            grant_elig_s;
    logic [A_W-1:0]  gbits_s;
    logic            a_fire_s;
    logic            d_dst_s;
    logic            d_fire_s;

    // Client eligibility: request pending and below the in-flight limit
    always_comb begin
        elig0_s = c0_a_valid & (inflight0_q < MAX_CNT);
        elig1_s = c1_a_valid & (inflight1_q < MAX_CNT);
    end

    // Grant selection.
    //   - A locked grant sticks to lock_idx.
    //   - Otherwise a lone eligible client wins.
    //   - Otherwise rr_ptr breaks the tie.
    always_comb begin
        grant_s = 1'b0;
        if (lock_q) begin
            grant_s = lock_idx_q;
        end else if (elig0_s && elig1_s) begin
            grant_s = rr_ptr_q;
        end else if (elig1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // A channel mux.
    //   - The client index is inserted above the client source.
    //   - Valid/ready outputs are forced low while reset_n is asserted.
    always_comb begin
        gbits_s      = c0_a_bits;
        grant_elig_s = 1'b0;
        if (grant_s) begin
            gbits_s      = c1_a_bits;
            grant_elig_s = elig1_s;
        end else begin
            gbits_s      = c0_a_bits;
            grant_elig_s = elig0_s;
        end
        m_a_valid  = reset_n & grant_elig_s;
        m_a_bits   = {gbits_s[A_W-1:A_SRC_TOP], grant_s, gbits_s[A_SRC_TOP-1:0]};
        c0_a_ready = reset_n & m_a_ready & ~grant_s & elig0_s;
        c1_a_ready = reset_n & m_a_ready &  grant_s & elig1_s;
        a_fire_s   = m_a_valid & m_a_ready;
    end

    // D channel routing.
    //   - The destination is the source MSB.
    //   - The stripped bits are broadcast to both clients.
    always_comb begin
        d_dst_s    = m_d_bits[D_SRC_MSB];
        c0_d_valid = reset_n & m_d_valid & ~d_dst_s;
        c1_d_valid = reset_n & m_d_valid &  d_dst_s;
        c0_d_bits  = {m_d_bits[D_W-1:D_SRC_MSB+1], m_d_bits[D_SRC_MSB-1:0]};
        c1_d_bits  = {m_d_bits[D_W-1:D_SRC_MSB+1], m_d_bits[D_SRC_MSB-1:0]};
        m_d_ready  = 1'b0;
        if (d_dst_s) begin
            m_d_ready = reset_n & c1_d_ready;
        end else begin
            m_d_ready = reset_n & c0_d_ready;
        end
        d_fire_s = m_d_valid & m_d_ready;
    end

    // Next-state logic for the round-robin pointer, the lock and the counters
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (a_fire_s) begin
            rr_ptr_d = ~grant_s;
            lock_d   = 1'b0;
        end else if (m_a_valid && !m_a_ready) begin
            // Stalled request: hold the grant until the manager accepts it.
            lock_d     = 1'b1;
            lock_idx_d = grant_s;
        end else begin
            lock_d     = lock_q;
            lock_idx_d = lock_idx_q;
        end
        inflight0_d = next_count(inflight0_q, a_fire_s & ~grant_s, d_fire_s & ~d_dst_s);
        inflight1_d = next_count(inflight1_q, a_fire_s &  grant_s, d_fire_s &  d_dst_s);
    end

    // Arbiter state registers.
    // Busy is taken from the next count, so it tracks the counter without lag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= 1'b0;
            lock_q      <= 1'b0;
            lock_idx_q  <= 1'b0;
            inflight0_q <= 3'd0;
            inflight1_q <= 3'd0;
            busy0_q     <= 1'b0;
            busy1_q     <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
            busy0_q     <= (inflight0_d != 3'd0);
            busy1_q     <= (inflight1_d != 3'd0);
        end
    end

    assign c0_busy = busy0_q;
    assign c1_busy = busy1_q;

`ifdef TL_UL_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant1_q, perf_stall_q;

    // Performance counters: per-client grants and manager stall cycles, wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0_q <= 32'd0;
            perf_grant1_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if (a_fire_s && !grant_s) begin
                perf_grant0_q <= perf_grant0_q + 32'd1;
            end
            if (a_fire_s && grant_s) begin
                perf_grant1_q <= perf_grant1_q + 32'd1;
            end
            if (m_a_valid && !m_a_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_tl_ul_client_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for tl_ul_client_arbiter (MAX_INFLIGHT=4, SRC_W=3).
//
// Scoreboard:
//   - Directed stimulus pushes the expected manager A beats and client D beats
//     into queues.
//   - A negedge monitor pops and compares them whenever a transfer fires.
//
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
// ---------------------------------------------------------------------------
module tb_tl_ul_client_arbiter;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         c0_a_valid, c1_a_valid, c0_a_ready, c1_a_ready;
    logic [80:0]  c0_a_bits, c1_a_bits;
    logic         m_a_valid, m_a_ready;
    logic [81:0]  m_a_bits;
    logic         m_d_valid, m_d_ready;
    logic [46:0]  m_d_bits;
    logic         c0_d_valid, c1_d_valid, c0_d_ready, c1_d_ready;
    logic [45:0]  c0_d_bits, c1_d_bits;
    logic         c0_busy, c1_busy;
`ifdef TL_UL_ARB_PERF_EN
    logic [31:0]  perf_grant0, perf_grant1, perf_stall;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [81:0] a_q[$];
    logic [46:0] d_q[$];   // {destination client, client D bits}

    always #5 clock = ~clock;

    tl_ul_client_arbiter #(.MAX_INFLIGHT(4), .SRC_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .c0_a_valid(c0_a_valid), .c0_a_ready(c0_a_ready), .c0_a_bits(c0_a_bits),
        .c1_a_valid(c1_a_valid), .c1_a_ready(c1_a_ready), .c1_a_bits(c1_a_bits),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_bits(m_a_bits),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_bits(m_d_bits),
        .c0_d_valid(c0_d_valid), .c0_d_ready(c0_d_ready), .c0_d_bits(c0_d_bits),
        .c1_d_valid(c1_d_valid), .c1_d_ready(c1_d_ready), .c1_d_bits(c1_d_bits),
        .c0_busy(c0_busy), .c1_busy(c1_busy)
`ifdef TL_UL_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Client A beat: {opcode, param, size, source, address, mask, data}.
    function automatic logic [80:0] mk_a(input logic [2:0] src, input logic [31:0] addr,
                                         input logic [31:0] data);
        return {3'd4, 3'd0, 4'd2, src, addr, 4'hF, data};
    endfunction

    // Manager D beat: {opcode, param, size, source, denied, data, corrupt}.
    function automatic logic [46:0] mk_d(input logic [3:0] src, input logic [31:0] data);
        return {3'd1, 2'd0, 4'd2, src, 1'b0, data, 1'b0};
    endfunction

    // Expected manager A beat: client index placed above the client source.
    function automatic logic [81:0] m_exp(input logic idx, input logic [80:0] b);
        return {b[80:71], idx, b[70:0]};
    endfunction

    // Expected scoreboard entry for a D beat: destination plus MSB-stripped bits.
    function automatic logic [46:0] d_exp(input logic [46:0] d);
        return {d[37], d[46:38], d[36:0]};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Issue one D response and let it fire (caller has set the client ready).
    task automatic send_d(input logic [3:0] src, input logic [31:0] data);
        logic [46:0] d;
        d = mk_d(src, data);
        m_d_bits  = d;
        m_d_valid = 1'b1;
        d_q.push_back(d_exp(d));
        cyc();
        m_d_valid = 1'b0;
        #1;
    endtask

    // Issue one A request from a single client with the manager ready.
    task automatic send_a(input logic idx, input logic [80:0] b);
        if (idx) begin
            c1_a_bits  = b;
            c1_a_valid = 1'b1;
        end else begin
            c0_a_bits  = b;
            c0_a_valid = 1'b1;
        end
        m_a_ready = 1'b1;
        a_q.push_back(m_exp(idx, b));
        cyc();
        c0_a_valid = 1'b0;
        c1_a_valid = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: compares every A and D transfer at the negedge
    always @(negedge clock) begin
        if (reset_n && m_a_valid && m_a_ready) begin
            if (a_q.size() == 0) begin
                check_eq("a_unexpected_fire", 128'd1, 128'd0);
            end else begin
                check_eq("a_bits", m_a_bits, a_q.pop_front());
            end
        end
        if (reset_n && m_d_valid && m_d_ready) begin
            check_eq("d_onehot", c0_d_valid ^ c1_d_valid, 1'b1);
            if (d_q.size() == 0) begin
                check_eq("d_unexpected_fire", 128'd1, 128'd0);
            end else begin
                check_eq("d_route_bits", {c1_d_valid, (c1_d_valid ? c1_d_bits : c0_d_bits)},
                         d_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [80:0] a0, a1, al, am, ab;
        logic [46:0] d;

        // Reset with active-looking inputs: all handshake outputs must be low.
        reset_n    = 1'b0;
        c0_a_valid = 1'b1; c1_a_valid = 1'b0; m_a_ready = 1'b1;
        c0_a_bits  = mk_a(3'd0, 32'h0, 32'h0); c1_a_bits = mk_a(3'd0, 32'h0, 32'h0);
        m_d_valid  = 1'b1; m_d_bits = mk_d(4'b0001, 32'h0);
        c0_d_ready = 1'b1; c1_d_ready = 1'b1;
        #3;
        check_eq("rst_m_a_valid", m_a_valid, 1'b0);
        check_eq("rst_c0_a_ready", c0_a_ready, 1'b0);
        check_eq("rst_m_d_ready", m_d_ready, 1'b0);
        check_eq("rst_c0_d_valid", c0_d_valid, 1'b0);
        check_eq("rst_busy", {c0_busy, c1_busy}, 2'b00);
`ifdef TL_UL_ARB_PERF_EN
        check_eq("rst_perf", {perf_grant0, perf_grant1, perf_stall}, 96'd0);
`endif
        cyc();
        cyc();
        reset_n    = 1'b1;
        c0_a_valid = 1'b0; m_a_ready = 1'b0; m_d_valid = 1'b0;
        c0_d_ready = 1'b0; c1_d_ready = 1'b0;
        cyc();

        // Both clients valid continuously: grants alternate 0,1,0,1.
        a0 = mk_a(3'd5, 32'h1000_0000, 32'hA5A5_0001);
        a1 = mk_a(3'd2, 32'h2000_0000, 32'h5A5A_0002);
        c0_a_bits = a0; c1_a_bits = a1;
        c0_a_valid = 1'b1; c1_a_valid = 1'b1; m_a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_q.push_back(m_exp(k[0], k[0] ? a1 : a0));
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("alt_ready", {c0_a_ready, c1_a_ready}, k[0] ? 2'b01 : 2'b10);
            cyc();
        end
        c0_a_valid = 1'b0; c1_a_valid = 1'b0;
        #1;
        check_eq("alt_busy", {c0_busy, c1_busy}, 2'b11);

        // Same-cycle A fire and D fire for client 1 (inflight1 = 2).
        ab = mk_a(3'd3, 32'h2000_0040, 32'h0000_0033);
        c1_a_bits = ab; c1_a_valid = 1'b1; m_a_ready = 1'b1;
        a_q.push_back(m_exp(1'b1, ab));
        d = mk_d(4'b1011, 32'hC0DE_0001);
        m_d_bits = d; m_d_valid = 1'b1; c1_d_ready = 1'b1;
        d_q.push_back(d_exp(d));
        #1;
        check_eq("same_cyc_ready", {c1_a_ready, m_d_ready}, 2'b11);
        cyc();
        c1_a_valid = 1'b0; m_d_valid = 1'b0;

        // D with source 4'b1010 while client 1 back-pressures for two cycles.
        d = mk_d(4'b1010, 32'hD00D_1010);
        m_d_bits = d; m_d_valid = 1'b1; c1_d_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("d_stall_valid", {c1_d_valid, c0_d_valid, m_d_ready}, 3'b100);
            check_eq("d_stall_src", c1_d_bits[36:34], 3'b010);
            cyc();
        end
        c1_d_ready = 1'b1;
        d_q.push_back(d_exp(d));
        #1;
        check_eq("d_release_ready", m_d_ready, 1'b1);
        cyc();
        m_d_valid = 1'b0;
        #1;
        // Counter was still 2 after the same-cycle fire, so one remains after this D.
        check_eq("c1_busy_after_2nd", c1_busy, 1'b1);
        send_d(4'b1100, 32'h0000_0003);
        check_eq("c1_busy_drained", c1_busy, 1'b0);
        // Stray response at zero must not wrap the counter.
        send_d(4'b1101, 32'h0000_0004);
        check_eq("c1_busy_stray", c1_busy, 1'b0);
        send_a(1'b1, mk_a(3'd7, 32'h2000_0080, 32'h0000_0055));
        check_eq("c1_busy_after_sat", c1_busy, 1'b1);
        send_d(4'b1111, 32'h0000_0005);
        check_eq("c1_busy_sat_drain", c1_busy, 1'b0);

        // Drain client 0, checking routing on the first response.
        c0_d_ready = 1'b1;
        d = mk_d(4'b0010, 32'h0000_0006);
        m_d_bits = d; m_d_valid = 1'b1;
        #1;
        check_eq("d_route_c0", {c0_d_valid, c1_d_valid}, 2'b10);
        d_q.push_back(d_exp(d));
        cyc();
        m_d_valid = 1'b0;
        #1;
        check_eq("c0_busy_one_left", c0_busy, 1'b1);
        send_d(4'b0011, 32'h0000_0007);
        check_eq("c0_busy_drained", c0_busy, 1'b0);

        // A single client-0 fire moves the round-robin pointer to client 1.
        send_a(1'b0, mk_a(3'd4, 32'h1000_0100, 32'h0000_0077));

        // Stall client 0 for three cycles. Client 1 joins in cycle 2 and must wait.
        al = mk_a(3'd6, 32'h8000_0000, 32'hDEAD_BEEF);
        a1 = mk_a(3'd1, 32'h4000_0000, 32'h0000_0099);
        c0_a_bits = al; c0_a_valid = 1'b1; m_a_ready = 1'b0; c1_a_bits = a1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                c1_a_valid = 1'b1;
            end
            #1;
            check_eq("lock_bits", {m_a_valid, m_a_bits}, {1'b1, m_exp(1'b0, al)});
            cyc();
        end
        m_a_ready = 1'b1;
        a_q.push_back(m_exp(1'b0, al));
        #1;
        check_eq("lock_fire_ready", {c0_a_ready, c1_a_ready}, 2'b10);
        cyc();
        c0_a_valid = 1'b0;
        a_q.push_back(m_exp(1'b1, a1));
        #1;
        check_eq("after_lock_c1", c1_a_ready, 1'b1);
        cyc();
        c1_a_valid = 1'b0;

        // In-flight limit: inflight0 = 2, two more fires reach MAX_INFLIGHT=4.
        am = mk_a(3'd1, 32'h1000_0200, 32'h0000_00AA);
        c0_a_bits = am; c0_a_valid = 1'b1; m_a_ready = 1'b1;
        a_q.push_back(m_exp(1'b0, am));
        a_q.push_back(m_exp(1'b0, am));
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("fill_ready", c0_a_ready, 1'b1);
            cyc();
        end
        #1;
        check_eq("max_blocked", {c0_a_ready, m_a_valid, c0_busy}, 3'b001);
        cyc();
        #1;
        check_eq("max_blocked_hold", c0_a_ready, 1'b0);
        d = mk_d(4'b0101, 32'h0000_0008);
        m_d_bits = d; m_d_valid = 1'b1;
        d_q.push_back(d_exp(d));
        #1;
        check_eq("max_blocked_dcyc", c0_a_ready, 1'b0);
        cyc();
        m_d_valid = 1'b0;
        a_q.push_back(m_exp(1'b0, am));
        #1;
        check_eq("max_reenable", c0_a_ready, 1'b1);
        cyc();
        c0_a_valid = 1'b0;

        // Reset while locked with inflight0 = 3 (inflight1 = 1).
        send_d(4'b0110, 32'h0000_0009);
        c0_a_bits = mk_a(3'd2, 32'h1000_0300, 32'h0000_00BB);
        c0_a_valid = 1'b1; m_a_ready = 1'b0;
        cyc();
        #1;
        check_eq("pre_rst_locked", {m_a_valid, c0_busy, c1_busy}, 3'b111);
        reset_n = 1'b0;
        m_d_bits = mk_d(4'b0111, 32'h0000_000A); m_d_valid = 1'b1;
        #1;
        check_eq("midrst_a", {m_a_valid, c0_a_ready, c1_a_ready}, 3'b000);
        check_eq("midrst_d", {m_d_ready, c0_d_valid, c1_d_valid}, 3'b000);
        check_eq("midrst_busy", {c0_busy, c1_busy}, 2'b00);
        cyc();
        reset_n = 1'b1;
        m_d_valid = 1'b0;
        #1;
        check_eq("post_rst_busy", {c0_busy, c1_busy}, 2'b00);
`ifdef TL_UL_ARB_PERF_EN
        check_eq("post_rst_perf", {perf_grant0, perf_grant1, perf_stall}, 96'd0);
`endif
        // rr_ptr back to 0: with both clients valid, client 0 wins first.
        a1 = mk_a(3'd5, 32'h4000_0100, 32'h0000_00CC);
        c1_a_bits = a1; c1_a_valid = 1'b1; m_a_ready = 1'b1;
        a_q.push_back(m_exp(1'b0, c0_a_bits));
        a_q.push_back(m_exp(1'b1, a1));
        #1;
        check_eq("post_rst_rr", {c0_a_ready, c1_a_ready}, 2'b10);
        cyc();
        #1;
        check_eq("post_rst_rr_next", {c0_a_ready, c1_a_ready}, 2'b01);
        cyc();
        c0_a_valid = 1'b0; c1_a_valid = 1'b0;
        cyc();

        check_eq("a_queue_empty", a_q.size(), 0);
        check_eq("d_queue_empty", d_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
